// File: rtl/det_sched.sv
// det_sched: time-shares one serial sequence detector among N_REQ requesters.
// Optional DET_SCHED_FIXED_PRIO_EN: lowest index wins, no round-robin pointer.
module det_sched #(
   parameter int   N_REQ     = 4,
   parameter int   FRAME_LEN = 8,
   parameter int   FLUSH_LEN = 2,
   parameter logic FLUSH_BIT = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*FRAME_LEN-1:0] frame,
   output logic                       x,
   input  logic                       y,
   output logic [N_REQ-1:0]           gnt,
   output logic                       busy,
   output logic [N_REQ-1:0]           ack,
   output logic                       hit
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(FRAME_LEN);
   localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
   localparam logic [FW-1:0] FL_LAST  = FW'(FLUSH_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [FRAME_LEN-1:0] sreg;
   logic [CW-1:0]        cnt;
   logic [FW-1:0]        fcnt;
   logic [IW-1:0]        win;
   logic [IW-1:0]        pick;
   logic                 found;
   logic                 acc;
   logic                 acc_f;
   int                   j;

`ifndef DET_SCHED_FIXED_PRIO_EN
   logic [IW-1:0]        ptr;

   // Last winner; reset value makes requester 0 the first candidate.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= IW'(N_REQ - 1);
      else if (state == IDLE && found)
         ptr <= pick;
   end
`endif

   // Arbiter: first asserted request in search order.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef DET_SCHED_FIXED_PRIO_EN
         j = k;
`else
         j = (int'(ptr) + 1 + k) % N_REQ;
`endif
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (found) state_nx = SHIFT;
         SHIFT: if (cnt == CNT_LAST) state_nx = FLUSH;
         FLUSH: if (fcnt == FL_LAST) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode from state and latched winner.
   always_comb begin
      gnt  = '0;
      ack  = '0;
      busy = (state != IDLE);
      x    = 1'b0;
      if (state != IDLE)
         gnt[win] = 1'b1;
      unique case (state)
         SHIFT: x = sreg[FRAME_LEN-1];
         FLUSH: x = FLUSH_BIT;
         DONE:  ack[win] = 1'b1;
         default: x = 1'b0;
      endcase
   end

   // y lags x by a cycle, so the first flush cycle carries the last bit's result.
   assign acc_f = acc | ((fcnt == '0) & y);

   // Datapath: frame capture, shifting, counters and hit accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
         fcnt <= '0;
         win  <= '0;
         acc  <= 1'b0;
         hit  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  win  <= pick;
                  sreg <= frame[int'(pick)*FRAME_LEN +: FRAME_LEN];
                  acc  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               sreg <= {sreg[FRAME_LEN-2:0], 1'b0};
               fcnt <= '0;
               if (cnt == CNT_LAST)
                  cnt <= '0;
               else
                  cnt <= cnt + 1'b1;
               // y in the first shift cycle belongs to the previous frame.
               if (cnt != '0)
                  acc <= acc | y;
            end
            FLUSH: begin
               acc <= acc_f;
               if (fcnt == FL_LAST) begin
                  hit  <= acc_f;
                  fcnt <= '0;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            DONE: begin
               cnt <= '0;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_det_sched.sv
// tb_det_sched: directed bench for det_sched with a Moore "101" detector.
// Expected values are hand-derived from the frames and timing below.
module tb_det_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] frame;
   logic        x;
   logic        y;
   logic [3:0]  gnt;
   logic        busy;
   logic [3:0]  ack;
   logic        hit;
   logic [1:0]  dst;

   int n_cmp;
   int n_bad;

   det_sched dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .frame (frame),
      .x     (x),
      .y     (y),
      .gnt   (gnt),
      .busy  (busy),
      .ack   (ack),
      .hit   (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Moore detector for 101: 0=none, 1=saw 1, 2=saw 10, 3=saw 101.
   always_ff @(posedge clk) begin
      if (rst)
         dst <= 2'd0;
      else
         case (dst)
            2'd0: dst <= x ? 2'd1 : 2'd0;
            2'd1: dst <= x ? 2'd1 : 2'd2;
            2'd2: dst <= x ? 2'd3 : 2'd0;
            default: dst <= x ? 2'd1 : 2'd2;
         endcase
   end
   assign y = (dst == 2'd3);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the grant cycle E; walks through E..E+11.
   task automatic run_frame(input int idx, input logic [7:0] fr,
                            input logic exp_hit);
      logic [3:0] oh;
      oh = 4'(1 << idx);
      for (int c = 0; c <= 10; c++) begin
         if (c == 0)
            req = 4'b0000;
         chk("gnt", 32'(gnt), 32'(oh));
         if (c < 8)
            chk("x_bit", 32'(x), 32'(fr[7-c]));
         else if (c < 10)
            chk("x_flush", 32'(x), 32'd0);
         chk("ack", 32'(ack), (c == 10) ? 32'(oh) : 32'd0);
         if (c == 10)
            chk("hit", 32'(hit), 32'(exp_hit));
         step();
      end
      chk("gnt_end", 32'(gnt), 32'd0);
      chk("busy_end", 32'(busy), 32'd0);
   endtask

   task automatic issue(input int idx, input logic [7:0] fr);
      req   = 4'(1 << idx);
      frame = '0;
      frame[idx*8 +: 8] = fr;
      step();
   endtask

   logic [3:0] rr_exp [5];
   logic [3:0] seen;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req   = '0;
      frame = '0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      rst = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single request with 101 at the front.
      issue(0, 8'b1010_0000);
      run_frame(0, 8'b1010_0000, 1'b1);

      // No match.
      issue(2, 8'b1100_1100);
      run_frame(2, 8'b1100_1100, 1'b0);

      // Pattern in the last three bits: needs the first flush sample.
      issue(3, 8'b0000_0101);
      run_frame(3, 8'b0000_0101, 1'b1);

      // Arbitration with all requests held.
      rst = 1'b1;
      step();
      rst = 1'b0;
`ifdef DET_SCHED_FIXED_PRIO_EN
      rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
      req   = 4'b1111;
      frame = {4{8'b1010_0000}};
      step();
      chk("arb0", 32'(gnt), 32'(rr_exp[0]));
      for (int k = 1; k < 5; k++) begin
         repeat (12) step();
         chk($sformatf("arb%0d", k), 32'(gnt), 32'(rr_exp[k]));
      end
      req = '0;
      for (int i = 0; i < 40 && busy; i++)
         step();
      chk("arb_idle", 32'(busy), 32'd0);
      chk("arb_hit", 32'(hit), 32'd1);

      // Reset in the middle of SHIFT.
      issue(0, 8'b1010_0000);
      chk("rs_busy0", 32'(busy), 32'd1);
      req = '0;
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("rs_gnt", 32'(gnt), 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_x", 32'(x), 32'd0);
      chk("rs_hit", 32'(hit), 32'd0);
      rst  = 1'b0;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         seen = seen | ack;
         step();
      end
      chk("rs_noack", 32'(seen), 32'd0);

      // Request dropped mid-frame still completes.
      req   = 4'b0010;
      frame = '0;
      frame[15:8] = 8'b1010_0000;
      step();
      chk("drop_gnt", 32'(gnt), 32'h2);
      repeat (3) step();
      req = '0;
      repeat (2) step();
      chk("drop_gnt5", 32'(gnt), 32'h2);
      repeat (5) step();
      chk("drop_ack", 32'(ack), 32'h2);
      chk("drop_hit", 32'(hit), 32'd1);
      step();
      chk("drop_ack_off", 32'(ack), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
